// File: rtl/i2c_pcf8574_target.sv
// i2c_pcf8574_target
// I2C target emulating the PCF8574 8-bit I/O expander found on HD44780 LCD
// backpacks. ACKs DEV_ADDR, latches each written byte onto port_out and
// returns port_in on reads. SCL/SDA are oversampled on clk_1MHz.
//
// Ports:
//   clk_1MHz   system clock
//   rst        synchronous active-high reset
//   scl        bus clock level (async)
//   sda_in     resolved bus data level (async)
//   sda_pull   1 = pull SDA low (open drain), 0 = release
//   port_in    byte returned on reads
//   port_out   last written data byte (P7..P0)
//   wr_strobe  one-cycle pulse when port_out updates
//   busy       high from an ACKed own address until STOP
//   addr_ack   one-cycle pulse when the own address is ACKed
module i2c_pcf8574_target #(
    parameter logic [6:0] DEV_ADDR = 7'h27,
    parameter logic [7:0] PORT_RST = 8'hFF
) (
    input  logic       clk_1MHz,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_pull,
    input  logic [7:0] port_in,
    output logic [7:0] port_out,
    output logic       wr_strobe,
    output logic       busy,
    output logic       addr_ack
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    // [0],[1] synchronizer, [2] history for edge detection. Reset to the
    // idle bus level so releasing reset never fakes an edge.
    logic [2:0] scl_sr, sda_sr;
    logic       scl_s, scl_h, sda_s, sda_h;
    logic       scl_rise, scl_fall, start_c, stop_c;

    assign scl_s = scl_sr[1];
    assign scl_h = scl_sr[2];
    assign sda_s = sda_sr[1];
    assign sda_h = sda_sr[2];

    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start_c  = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_c   = scl_s & scl_h & ~sda_h & sda_s;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] port_q, port_d;
    logic       rw_q, rw_d;
    logic       pull_q, pull_d;
    logic       busy_q, busy_d;
    logic       wr_stb_q, wr_stb_d;
    logic       aa_q, aa_d;

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            scl_sr    <= 3'b111;
            sda_sr    <= 3'b111;
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            shreg_q   <= 8'h00;
            port_q    <= PORT_RST;
            rw_q      <= 1'b0;
            pull_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            aa_q      <= 1'b0;
        end else begin
            scl_sr    <= {scl_sr[1:0], scl};
            sda_sr    <= {sda_sr[1:0], sda_in};
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            port_q    <= port_d;
            rw_q      <= rw_d;
            pull_q    <= pull_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            aa_q      <= aa_d;
        end
    end

    // All SDA drive changes happen on a synchronized SCL fall, so the line
    // only moves while SCL is low (START/STOP/reset excepted).
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        port_d    = port_q;
        rw_d      = rw_q;
        pull_d    = pull_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        aa_d      = 1'b0;
        if (start_c) begin
            // START wins over any SCL edge in the same cycle
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            pull_d    = 1'b0;
        end else if (stop_c) begin
            state_d = IDLE;
            pull_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, WR_DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shreg_d   = {shreg_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == WR_DATA) begin
                            port_d   = shreg_q;
                            wr_stb_d = 1'b1;
                            pull_d   = 1'b1;
                            state_d  = WR_ACK;
                        end else if (shreg_q[7:1] == DEV_ADDR) begin
                            pull_d  = 1'b1;
                            aa_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shreg_q[0];
                            state_d = ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            shreg_d = port_in;
                            pull_d  = ~port_in[7];
                            state_d = RD_DATA;
                        end else begin
                            pull_d  = 1'b0;
                            state_d = WR_DATA;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        pull_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WR_DATA;
                    end
                end
                RD_DATA: begin
                    // bit_cnt counts bits the master has clocked in
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        pull_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = RD_ACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        pull_d  = ~shreg_q[6];
                    end
                end
                RD_ACK: begin
                    // bit_cnt=1 marks "master ACKed, reload at next fall"
                    if (scl_rise) begin
                        if (sda_s) state_d = IGNORE;
                        else       bit_cnt_d = 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        shreg_d   = port_in;
                        pull_d    = ~port_in[7];
                        bit_cnt_d = 4'd0;
                        state_d   = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_pull  = pull_q;
    assign port_out  = port_q;
    assign wr_strobe = wr_stb_q;
    assign busy      = busy_q;
    assign addr_ack  = aa_q;

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
module tb_i2c_pcf8574_target;

    localparam logic [6:0] DEV = 7'h27;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_in;
    logic       sda_pull;
    logic [7:0] port_in;
    logic [7:0] port_out;
    logic       wr_strobe, busy, addr_ack;

    assign sda_in = sda_m & ~sda_pull;

    i2c_pcf8574_target #(.DEV_ADDR(DEV), .PORT_RST(8'hFF)) dut (
        .clk_1MHz (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_in),
        .sda_pull (sda_pull),
        .port_in  (port_in),
        .port_out (port_out),
        .wr_strobe(wr_strobe),
        .busy     (busy),
        .addr_ack (addr_ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int n_wr = 0, n_aa = 0, n_pull = 0;
    int exp_wr = 0, exp_aa = 0;
    logic [7:0] ref_po = 8'hFF;
    logic [7:0] txd [4];

    always @(negedge clk) begin
        if (wr_strobe) n_wr++;
        if (addr_ack)  n_aa++;
        if (sda_pull)  n_pull++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_clk(2);
        scl = 1'b1; wait_clk(5);
        scl = 1'b0; wait_clk(3);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_clk(2);
        scl = 1'b1; wait_clk(3);
        b = sda_in; wait_clk(2);
        scl = 1'b0; wait_clk(3);
    endtask

    // plain START from idle bus, repeated START if SCL is currently low
    task automatic i2c_start();
        if (scl) begin
            sda_m = 1'b0; wait_clk(5);
            scl = 1'b0; wait_clk(3);
        end else begin
            sda_m = 1'b1; wait_clk(2);
            scl = 1'b1; wait_clk(5);
            sda_m = 1'b0; wait_clk(5);
            scl = 1'b0; wait_clk(3);
        end
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(2);
        scl = 1'b1; wait_clk(5);
        sda_m = 1'b1; wait_clk(5);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(r);
            b[i] = r;
        end
        send_bit(~ack);
    endtask

    // One transaction against the reference: an address equal to DEV is
    // ACKed, writes land on port_out, reads return port_in; anything else
    // sees a silent bus (NACK, 0xFF) and no side effects.
    task automatic run_txn(input logic [6:0] a, input logic rd, input int nb, input logic do_stop);
        logic       ack, match;
        logic [7:0] rb;
        int         p0;
        match = (a == DEV);
        p0 = n_pull;
        i2c_start();
        write_byte({a, rd}, ack);
        chk("addr_ack_bit", ack, match);
        if (match) begin
            exp_aa++;
            chk("busy_set", busy, 1'b1);
        end
        for (int i = 0; i < nb; i++) begin
            if (!rd) begin
                write_byte(txd[i], ack);
                chk("data_ack_bit", ack, match);
                if (match) begin
                    ref_po = txd[i];
                    exp_wr++;
                end
            end else begin
                read_byte(i < nb - 1, rb);
                chk("read_data", rb, match ? port_in : 8'hFF);
            end
        end
        if (rd) begin
            p0 = n_pull;
            wait_clk(10);
            chk("released_after_nack", n_pull, p0);
        end
        if (!match) chk("no_drive_mismatch", n_pull, p0);
        if (do_stop) begin
            i2c_stop();
            wait_clk(4);
            chk("busy_after_stop", busy, 1'b0);
        end
        chk("port_out", port_out, ref_po);
        chk("wr_strobes", n_wr, exp_wr);
        chk("addr_acks", n_aa, exp_aa);
    endtask

    initial begin
        logic       ack;
        logic [6:0] a;
        logic [7:0] b;
        rst = 1'b1; scl = 1'b1; sda_m = 1'b1; port_in = 8'h00;
        wait_clk(2);
        chk("rst_port_out", port_out, 8'hFF);
        chk("rst_sda_pull", sda_pull, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", n_wr + n_aa, 0);
        rst = 1'b0;
        wait_clk(5);

        // write 0x0C to own address
        txd[0] = 8'h0C;
        run_txn(7'h27, 1'b0, 1, 1'b1);
        // foreign address 0x26
        txd[0] = 8'h55;
        run_txn(7'h26, 1'b0, 1, 1'b1);
        // read A5 with NACK
        port_in = 8'hA5;
        run_txn(7'h27, 1'b1, 1, 1'b1);
        // write 08, repeated START, read two bytes
        txd[0] = 8'h08;
        port_in = 8'h3E;
        run_txn(7'h27, 1'b0, 1, 1'b0);
        run_txn(7'h27, 1'b1, 2, 1'b1);

        // reset while the target holds the data ACK low
        i2c_start();
        write_byte({DEV, 1'b0}, ack);
        chk("t6_addr_ack", ack, 1'b1);
        exp_aa++;
        b = 8'h3C;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        exp_wr++;
        sda_m = 1'b1; wait_clk(2);
        scl = 1'b1; wait_clk(2);
        chk("t6_pull_in_ack", sda_pull, 1'b1);
        rst = 1'b1;
        wait_clk(1);
        chk("t6_pull_dropped", sda_pull, 1'b0);
        chk("t6_port_rst", port_out, 8'hFF);
        chk("t6_busy_rst", busy, 1'b0);
        ref_po = 8'hFF;
        rst = 1'b0;
        wait_clk(3);
        scl = 1'b0; wait_clk(3);
        i2c_stop();
        wait_clk(4);
        txd[0] = 8'h9A; txd[1] = 8'h01;
        run_txn(7'h27, 1'b0, 2, 1'b1);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) a = DEV;
            else begin
                a = 7'($urandom_range(0, 126));
                if (a >= DEV) a = a + 7'd1;
            end
            for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
            port_in = 8'($urandom);
            run_txn(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
